// File: rtl/multadd_pkg.sv
// Shared widths, FSM state type and frame-length decode for the multiply-add accumulator.
package multadd_pkg;

    localparam int DATA_W = 17;
    localparam int LEN_W  = 4;
    localparam int SUM_W  = 21;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } stateT;

    // A length code of zero means a full 16-sample frame.
    function automatic logic [CNT_W-1:0] frameLen(input logic [LEN_W-1:0] lenCode);
        logic [CNT_W-1:0] result;
        if (lenCode == 4'd0) begin
            result = 5'd16;
        end else begin
            result = {1'b0, lenCode};
        end
        return result;
    endfunction

endpackage

// File: rtl/multadd_if.sv
// Sample/result bus between the multiply-add producer, the accumulator and the sum consumer.
interface multadd_if import multadd_pkg::*; ();

    logic              iVALID;
    logic [DATA_W-1:0] iDATA;
    logic              oREADY;
    logic [LEN_W-1:0]  iLEN;
    logic              iCLEAR;
    logic [SUM_W-1:0]  oSUM;
    logic              oVALID;
    logic              iACK;
    logic [CNT_W-1:0]  oCOUNT;

    modport master (
        output iVALID, iDATA, iLEN, iCLEAR, iACK,
        input  oREADY, oSUM, oVALID, oCOUNT
    );

    modport slave (
        input  iVALID, iDATA, iLEN, iCLEAR, iACK,
        output oREADY, oSUM, oVALID, oCOUNT
    );

endinterface

// File: rtl/multadd_acc.sv
// Frame accumulator: sums 1..16 multiply-add results, then holds the sum until acknowledged.
module multadd_acc import multadd_pkg::*; (
    input  logic     iCLK,
    input  logic     iRST,
    multadd_if.slave bus
);

    stateT            stateR, stateS;
    logic [SUM_W-1:0] accR, accS;
    logic [SUM_W-1:0] sumR, sumS;
    logic [SUM_W-1:0] addS;
    logic [SUM_W-1:0] dataExtS;
    logic [CNT_W-1:0] countR, countS;
    logic [CNT_W-1:0] incS;
    logic [CNT_W-1:0] lenR, lenS;
    logic [CNT_W-1:0] newLenS;
    logic             validR, validS;
    logic             readyR, readyS;
    logic             acceptS;

    // Next-state and next-output logic; the 21-bit adder cannot overflow for 16 samples.
    always_comb begin
        stateS   = stateR;
        accS     = accR;
        sumS     = sumR;
        countS   = countR;
        lenS     = lenR;
        validS   = validR;
        readyS   = readyR;
        acceptS  = bus.iVALID & readyR;
        dataExtS = {4'd0, bus.iDATA};
        addS     = accR + dataExtS;
        incS     = countR + 5'd1;
        newLenS  = frameLen(bus.iLEN);

        if (bus.iCLEAR) begin
            stateS = IDLE;
            accS   = 21'd0;
            sumS   = 21'd0;
            countS = 5'd0;
            validS = 1'b0;
            readyS = 1'b1;
        end else begin
            case (stateR)
                IDLE: begin
                    if (acceptS) begin
                        accS   = dataExtS;
                        countS = 5'd1;
                        lenS   = newLenS;
                        if (newLenS == 5'd1) begin
                            stateS = HOLD;
                            sumS   = dataExtS;
                            validS = 1'b1;
                            readyS = 1'b0;
                        end else begin
                            stateS = ACCUM;
                        end
                    end else begin
                        stateS = IDLE;
                    end
                end
                ACCUM: begin
                    if (acceptS) begin
                        accS   = addS;
                        countS = incS;
                        if (incS == lenR) begin
                            stateS = HOLD;
                            sumS   = addS;
                            validS = 1'b1;
                            readyS = 1'b0;
                        end else begin
                            stateS = ACCUM;
                        end
                    end else begin
                        stateS = ACCUM;
                    end
                end
                HOLD: begin
                    // Incoming samples are dropped here; only the acknowledge matters.
                    if (bus.iACK) begin
                        stateS = IDLE;
                        accS   = 21'd0;
                        countS = 5'd0;
                        validS = 1'b0;
                        readyS = 1'b1;
                    end else begin
                        stateS = HOLD;
                    end
                end
                default: begin
                    stateS = IDLE;
                    accS   = 21'd0;
                    sumS   = 21'd0;
                    countS = 5'd0;
                    validS = 1'b0;
                    readyS = 1'b1;
                end
            endcase
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            stateR <= IDLE;
            accR   <= 21'd0;
            sumR   <= 21'd0;
            countR <= 5'd0;
            lenR   <= 5'd16;
            validR <= 1'b0;
            readyR <= 1'b1;
        end else begin
            stateR <= stateS;
            accR   <= accS;
            sumR   <= sumS;
            countR <= countS;
            lenR   <= lenS;
            validR <= validS;
            readyR <= readyS;
        end
    end

    assign bus.oREADY = readyR;
    assign bus.oVALID = validR;
    assign bus.oSUM   = sumR;
    assign bus.oCOUNT = countR;

endmodule

// File: tb/tb_multadd_acc.sv
// Self-checking bench for multadd_acc: directed frames plus randomized frames against a sum model.
module tb_multadd_acc;
    import multadd_pkg::*;

    logic iCLK = 1'b0;
    logic iRST;
    int   passCnt  = 0;
    int   totalCnt = 0;

    multadd_if bus ();

    multadd_acc dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    always #5 iCLK = ~iCLK;

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic push(input logic [16:0] d);
        bus.iVALID = 1'b1;
        bus.iDATA  = d;
        step();
        bus.iVALID = 1'b0;
    endtask

    task automatic test_reset();
        iRST = 1'b1;
        bus.iVALID = 1'b0; bus.iDATA = 17'd0; bus.iLEN = 4'd0; bus.iCLEAR = 1'b0; bus.iACK = 1'b0;
        #12;
        totalCnt++; if (bus.oVALID !== 1'b0) $display("FAIL reset_valid: got %0d expected 0", bus.oVALID); else passCnt++;
        totalCnt++; if (bus.oREADY !== 1'b1) $display("FAIL reset_ready: got %0d expected 1", bus.oREADY); else passCnt++;
        totalCnt++; if (bus.oSUM !== 21'd0) $display("FAIL reset_sum: got %0d expected 0", bus.oSUM); else passCnt++;
        totalCnt++; if (bus.oCOUNT !== 5'd0) $display("FAIL reset_count: got %0d expected 0", bus.oCOUNT); else passCnt++;
        @(negedge iCLK);
        iRST = 1'b0;
        step();
    endtask

    task automatic test_basic();
        bus.iLEN = 4'd4;
        for (int i = 0; i < 3; i++) push(17'd13);
        totalCnt++; if (bus.oVALID !== 1'b0 || bus.oCOUNT !== 5'd3) $display("FAIL basic_mid: got valid=%0d count=%0d expected valid=0 count=3", bus.oVALID, bus.oCOUNT); else passCnt++;
        push(17'd13);
        totalCnt++; if (bus.oVALID !== 1'b1) $display("FAIL basic_valid: got %0d expected 1", bus.oVALID); else passCnt++;
        totalCnt++; if (bus.oSUM !== 21'd52) $display("FAIL basic_sum: got %0d expected 52", bus.oSUM); else passCnt++;
        totalCnt++; if (bus.oCOUNT !== 5'd4) $display("FAIL basic_count: got %0d expected 4", bus.oCOUNT); else passCnt++;
        totalCnt++; if (bus.oREADY !== 1'b0) $display("FAIL basic_ready: got %0d expected 0", bus.oREADY); else passCnt++;
        bus.iACK = 1'b1; step(); bus.iACK = 1'b0;
        totalCnt++; if (bus.oVALID !== 1'b0 || bus.oREADY !== 1'b1 || bus.oCOUNT !== 5'd0) $display("FAIL basic_ack: got valid=%0d ready=%0d count=%0d expected 0/1/0", bus.oVALID, bus.oREADY, bus.oCOUNT); else passCnt++;
    endtask

    task automatic test_max();
        bus.iLEN = 4'd0;
        for (int i = 0; i < 16; i++) push(17'd130050);
        totalCnt++; if (bus.oSUM !== 21'd2080800) $display("FAIL max_sum: got %0d expected 2080800", bus.oSUM); else passCnt++;
        totalCnt++; if (bus.oCOUNT !== 5'd16 || bus.oVALID !== 1'b1) $display("FAIL max_count: got count=%0d valid=%0d expected 16/1", bus.oCOUNT, bus.oVALID); else passCnt++;
        bus.iACK = 1'b1; step(); bus.iACK = 1'b0;
    endtask

    task automatic test_len1_hold();
        bus.iLEN = 4'd1;
        push(17'd29);
        totalCnt++; if (bus.oVALID !== 1'b1 || bus.oSUM !== 21'd29) $display("FAIL len1_sum: got valid=%0d sum=%0d expected 1/29", bus.oVALID, bus.oSUM); else passCnt++;
        bus.iVALID = 1'b1; bus.iDATA = 17'd77;
        for (int i = 0; i < 3; i++) begin
            step();
            totalCnt++; if (bus.oSUM !== 21'd29 || bus.oCOUNT !== 5'd1 || bus.oREADY !== 1'b0) $display("FAIL len1_hold: got sum=%0d count=%0d ready=%0d expected 29/1/0", bus.oSUM, bus.oCOUNT, bus.oREADY); else passCnt++;
        end
        bus.iACK = 1'b1; step(); bus.iACK = 1'b0; bus.iVALID = 1'b0;
        totalCnt++; if (bus.oVALID !== 1'b0 || bus.oREADY !== 1'b1 || bus.oCOUNT !== 5'd0) $display("FAIL len1_ack: got valid=%0d ready=%0d count=%0d expected 0/1/0", bus.oVALID, bus.oREADY, bus.oCOUNT); else passCnt++;
    endtask

    task automatic test_gaps_len_change();
        bus.iLEN = 4'd3;
        push(17'd5);
        bus.iLEN = 4'd1;
        step(); step();
        push(17'd7);
        totalCnt++; if (bus.oVALID !== 1'b0 || bus.oCOUNT !== 5'd2) $display("FAIL gaps_mid: got valid=%0d count=%0d expected 0/2", bus.oVALID, bus.oCOUNT); else passCnt++;
        push(17'd9);
        totalCnt++; if (bus.oVALID !== 1'b1 || bus.oSUM !== 21'd21) $display("FAIL gaps_sum: got valid=%0d sum=%0d expected 1/21", bus.oVALID, bus.oSUM); else passCnt++;
        bus.iACK = 1'b1; step(); bus.iACK = 1'b0;
    endtask

    task automatic test_clear();
        bus.iLEN = 4'd4;
        push(17'd100); push(17'd100);
        bus.iCLEAR = 1'b1; bus.iVALID = 1'b1; bus.iDATA = 17'd500;
        step();
        bus.iCLEAR = 1'b0; bus.iVALID = 1'b0;
        totalCnt++; if (bus.oCOUNT !== 5'd0 || bus.oSUM !== 21'd0 || bus.oVALID !== 1'b0) $display("FAIL clear_state: got count=%0d sum=%0d valid=%0d expected 0/0/0", bus.oCOUNT, bus.oSUM, bus.oVALID); else passCnt++;
        for (int i = 0; i < 4; i++) push(17'd1);
        totalCnt++; if (bus.oVALID !== 1'b1 || bus.oSUM !== 21'd4) $display("FAIL clear_sum: got valid=%0d sum=%0d expected 1/4", bus.oVALID, bus.oSUM); else passCnt++;
        bus.iACK = 1'b1; step(); bus.iACK = 1'b0;
    endtask

    task automatic test_reset_midframe();
        bus.iLEN = 4'd4;
        for (int i = 0; i < 3; i++) push(17'd50);
        #2 iRST = 1'b1;
        #1;
        totalCnt++; if (bus.oCOUNT !== 5'd0 || bus.oSUM !== 21'd0 || bus.oVALID !== 1'b0 || bus.oREADY !== 1'b1) $display("FAIL rst_async: got count=%0d sum=%0d valid=%0d ready=%0d expected 0/0/0/1", bus.oCOUNT, bus.oSUM, bus.oVALID, bus.oREADY); else passCnt++;
        @(negedge iCLK);
        iRST = 1'b0;
        step();
        bus.iLEN = 4'd2;
        push(17'd6); push(17'd6);
        totalCnt++; if (bus.oVALID !== 1'b1 || bus.oSUM !== 21'd12 || bus.oCOUNT !== 5'd2) $display("FAIL rst_newframe: got valid=%0d sum=%0d count=%0d expected 1/12/2", bus.oVALID, bus.oSUM, bus.oCOUNT); else passCnt++;
        bus.iACK = 1'b1; step(); bus.iACK = 1'b0;
    endtask

    // Each frame's expected sum is just the arithmetic total of the samples sent.
    task automatic test_random();
        int samples[$];
        int expSum;
        int effLen;
        int lenCode;
        for (int f = 0; f < 20; f++) begin
            samples.delete();
            lenCode = $urandom_range(0, 15);
            effLen  = (lenCode == 0) ? 16 : lenCode;
            bus.iLEN = lenCode[3:0];
            for (int i = 0; i < effLen; i++) begin
                int gaps;
                int d;
                gaps = $urandom_range(0, 2);
                for (int g = 0; g < gaps; g++) begin
                    bus.iVALID = 1'b0;
                    bus.iACK   = ($urandom_range(0, 1) == 1);
                    step();
                    bus.iACK = 1'b0;
                end
                totalCnt++; if (bus.oCOUNT !== i[4:0]) $display("FAIL rand_gap_count: frame %0d got %0d expected %0d", f, bus.oCOUNT, i); else passCnt++;
                d = $urandom_range(0, 130050);
                samples.push_back(d);
                push(d[16:0]);
                if (i == 0) bus.iLEN = 4'($urandom_range(0, 15));
                totalCnt++; if (bus.oCOUNT !== 5'(i + 1) || bus.oVALID !== (i + 1 == effLen)) $display("FAIL rand_progress: frame %0d got count=%0d valid=%0d expected %0d/%0d", f, bus.oCOUNT, bus.oVALID, i + 1, (i + 1 == effLen)); else passCnt++;
            end
            expSum = 0;
            foreach (samples[k]) expSum += samples[k];
            totalCnt++; if (bus.oSUM !== expSum[20:0]) $display("FAIL rand_sum: frame %0d len %0d got %0d expected %0d", f, effLen, bus.oSUM, expSum); else passCnt++;
            for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
                bus.iVALID = 1'b1; bus.iDATA = 17'($urandom_range(0, 130050));
                step();
                totalCnt++; if (bus.oSUM !== expSum[20:0] || bus.oREADY !== 1'b0 || bus.oCOUNT !== 5'(effLen)) $display("FAIL rand_hold: frame %0d got sum=%0d ready=%0d count=%0d expected %0d/0/%0d", f, bus.oSUM, bus.oREADY, bus.oCOUNT, expSum, effLen); else passCnt++;
            end
            bus.iVALID = ($urandom_range(0, 1) == 1);
            bus.iACK = 1'b1; step(); bus.iACK = 1'b0; bus.iVALID = 1'b0;
            totalCnt++; if (bus.oVALID !== 1'b0 || bus.oREADY !== 1'b1 || bus.oCOUNT !== 5'd0) $display("FAIL rand_ack: frame %0d got valid=%0d ready=%0d count=%0d expected 0/1/0", f, bus.oVALID, bus.oREADY, bus.oCOUNT); else passCnt++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_len1_hold();
        test_gaps_len_change();
        test_clear();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
